// File: rtl/tlut_pkg.sv
// tlut_pkg: shared FSM states and sizing helpers for the temporal-LUT dot-product engine
package tlut_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    function automatic int acc_width(int iw, int ww, int dim_a);
        return ww + iw + $clog2(dim_a);
    endfunction

    // prec of 0 or wider than the input selects the full input width
    function automatic logic [31:0] prec_mask(int prec, int iw);
        return ~(32'hFFFF_FFFF << ((prec <= 0 || prec > iw) ? iw : prec));
    endfunction

endpackage

// File: rtl/tlut_adder_tree.sv
// tlut_adder_tree: balanced binary sum of the enabled operands, each sign- or zero-extended to IN_W
module tlut_adder_tree #(
    parameter int N    = 4,
    parameter int OP_W = 8,
    parameter int IN_W = 14,
    parameter bit SIGNED = 1'b0
)(
    input  logic [N-1:0][OP_W-1:0] op_i,
    input  logic [N-1:0]           en_i,
    output logic [IN_W-1:0]        sum_o
);

    localparam int P = 1 << $clog2(N);

    // heap layout: leaves at P..2P-1, node i sums children 2i and 2i+1
    logic [IN_W-1:0] node [1:2*P-1];

    always_comb begin
        node = '{default: '0};
        for (int i = 0; i < N; i++)
            node[P+i] = !en_i[i] ? '0 : SIGNED ? IN_W'($signed(op_i[i])) : IN_W'(op_i[i]);
        for (int i = P - 1; i >= 1; i--)
            node[i] = node[2*i] + node[2*i+1];
    end

    assign sum_o = node[1];

endmodule

// File: rtl/tlut_dot_engine.sv
// tlut_dot_engine: DIM_C dot products via unary temporal coding; a counter sweeps up to max(x)
// and each cycle adds the weights whose input still exceeds it into per-channel accumulators.
module tlut_dot_engine
    import tlut_pkg::*;
#(
    parameter int DIM_A        = 4,
    parameter int DIM_C        = 4,
    parameter int INPUT_WIDTH  = 4,
    parameter int WEIGHT_WIDTH = 8,
    parameter int W_SIGNED     = 0,
    parameter int ACC_WIDTH    = acc_width(INPUT_WIDTH, WEIGHT_WIDTH, DIM_A)
)(
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [DIM_A-1:0][INPUT_WIDTH-1:0]             in_x,
    input  logic [DIM_C-1:0][DIM_A-1:0][WEIGHT_WIDTH-1:0] in_w,
    input  logic [$clog2(INPUT_WIDTH):0]                  in_prec,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [DIM_C-1:0][ACC_WIDTH-1:0]               out_y,
    output logic                                          busy
);

    state_e                                    state_q, state_d;
    logic [INPUT_WIDTH-1:0]                    cnt_q;
    logic [DIM_A-1:0][INPUT_WIDTH-1:0]         x_q;
    logic [DIM_C-1:0][DIM_A-1:0][WEIGHT_WIDTH-1:0] w_q;
    logic [DIM_C-1:0][ACC_WIDTH-1:0]           acc_q, sum;
    logic [DIM_A-1:0]                          temporal;
    logic [INPUT_WIDTH-1:0]                    mask;
    logic                                      accept, active;

    assign mask      = INPUT_WIDTH'(prec_mask(int'(in_prec), INPUT_WIDTH));
    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign active    = |temporal;
    assign out_valid = state_q == DONE;
    assign busy      = state_q == RUN;
    assign out_y     = acc_q;

    for (genvar a = 0; a < DIM_A; a++) begin : g_tmp
        assign temporal[a] = x_q[a] > cnt_q;
    end

    for (genvar c = 0; c < DIM_C; c++) begin : g_ch
        tlut_adder_tree #(
            .N(DIM_A), .OP_W(WEIGHT_WIDTH), .IN_W(ACC_WIDTH), .SIGNED(W_SIGNED != 0)
        ) u_tree (
            .op_i(w_q[c]), .en_i(temporal), .sum_o(sum[c])
        );
    end

    // an accept always wins, which gives back-to-back operation straight out of DONE
    always_comb begin
        state_d = state_q;
        if (accept)
            state_d = RUN;
        else if (state_q == RUN && !active)
            state_d = DONE;
        else if (state_q == DONE && out_ready)
            state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            w_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                x_q   <= in_x & {DIM_A{mask}};
                w_q   <= in_w;
                acc_q <= '0;
                cnt_q <= '0;
            end else if (state_q == RUN && active) begin
                cnt_q <= cnt_q + 1'b1;
                for (int c = 0; c < DIM_C; c++)
                    acc_q[c] <= acc_q[c] + sum[c];
            end
        end
    end

endmodule

// File: tb/tb_tlut_dot_engine.sv
// tb_tlut_dot_engine: unsigned and signed-weight engines share one stimulus stream; a
// scoreboard holds arithmetic expectations and a monitor checks every result presented.
module tb_tlut_dot_engine;

    localparam int DA = 4, DC = 2, IW = 4, WW = 8, ACC = 14;

    typedef struct {
        logic [DC-1:0][ACC-1:0] yu;
        logic [DC-1:0][ACC-1:0] ys;
        int done;
        int m;
    } exp_t;

    logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic [DA-1:0][IW-1:0]         in_x = '0;
    logic [DC-1:0][DA-1:0][WW-1:0] in_w = '0;
    logic [2:0]                    in_prec = '0;
    logic rdy_u, rdy_s, ov_u, ov_s, busy_u, busy_s;
    logic [DC-1:0][ACC-1:0] y_u, y_s;
    int vectors = 0, miscompares = 0, cyc = 0, or_force = -1;
    int bcnt = 0;
    bit fresh = 1;
    exp_t q[$];

    tlut_dot_engine #(.DIM_A(DA), .DIM_C(DC), .INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW), .W_SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_u), .in_x(in_x), .in_w(in_w),
        .in_prec(in_prec), .out_valid(ov_u), .out_ready(out_ready), .out_y(y_u), .busy(busy_u));

    tlut_dot_engine #(.DIM_A(DA), .DIM_C(DC), .INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW), .W_SIGNED(1)) s_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s), .in_x(in_x), .in_w(in_w),
        .in_prec(in_prec), .out_valid(ov_s), .out_ready(out_ready), .out_y(y_s), .busy(busy_s));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // dot products straight from the definition: y[c] = sum over a of w[c][a] * masked x[a]
    function automatic exp_t model(input logic [DA-1:0][IW-1:0] x,
                                   input logic [DC-1:0][DA-1:0][WW-1:0] w,
                                   input logic [2:0] p, input int t);
        exp_t e;
        int bits, su, ss;
        int xm[DA];
        bits = (p == 0 || p > IW) ? IW : int'(p);
        e.m = 0;
        for (int a = 0; a < DA; a++) begin
            xm[a] = int'(x[a]) % (1 << bits);
            if (xm[a] > e.m) e.m = xm[a];
        end
        for (int c = 0; c < DC; c++) begin
            su = 0;
            ss = 0;
            for (int a = 0; a < DA; a++) begin
                su += xm[a] * int'(w[c][a]);
                ss += xm[a] * int'($signed(w[c][a]));
            end
            e.yu[c] = ACC'(su);
            e.ys[c] = ACC'(ss);
        end
        e.done = t + e.m + 1;
        return e;
    endfunction

    task automatic send(input logic [DA-1:0][IW-1:0] x, input logic [DC-1:0][DA-1:0][WW-1:0] w,
                        input logic [2:0] p);
        int n = 0;
        @(posedge clk); #1;
        in_x = x; in_w = w; in_prec = p; in_valid = 1;
        @(negedge clk);
        while (!rdy_u && n < 300) begin @(negedge clk); n++; end
        if (!rdy_u) chk("in_ready_timeout", rdy_u, 1);
        q.push_back(model(x, w, p, cyc + 1));
        @(posedge clk); #1;
        in_valid = 0;
        in_x = 16'($urandom);
        in_w = {$urandom, $urandom};
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
        chk("drain", 64'(q.size()), 0);
    endtask

    initial forever begin
        @(posedge clk); #2;
        out_ready = (or_force < 0) ? ($urandom_range(0, 3) != 0) : (or_force != 0);
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                fresh = 1;
                bcnt = 0;
                chk("rst_out_valid", ov_u, 0);
                chk("rst_busy", busy_u, 0);
                chk("rst_in_ready", rdy_u, 1);
                chk("rst_out_y_u", y_u, 0);
                chk("rst_out_y_s", y_s, 0);
            end else begin
                bcnt += int'(busy_u);
                if (ov_u && q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_output: out_valid=1 with nothing pending (cycle %0d)", cyc);
                end else if (ov_u) begin
                    e = q[0];
                    if (fresh) begin
                        chk("latency_cycle", cyc, e.done);
                        chk("busy_cycles", bcnt, e.m + 1);
                        fresh = 0;
                    end
                    chk("out_valid_s", ov_s, 1);
                    for (int c = 0; c < DC; c++) begin
                        chk($sformatf("y_unsigned[%0d]", c), y_u[c], e.yu[c]);
                        chk($sformatf("y_signed[%0d]", c), y_s[c], e.ys[c]);
                    end
                    if (out_ready) begin
                        void'(q.pop_front());
                        fresh = 1;
                        bcnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        logic [DA-1:0][IW-1:0]         x;
        logic [DC-1:0][DA-1:0][WW-1:0] w;
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        x = {4'd7, 4'd15, 4'd0, 4'd3};
        w = {{4{8'd255}}, {8'd4, 8'd3, 8'd2, 8'd1}};
        send(x, w, 0);
        send('0, {$urandom, $urandom}, 0);
        x = {4'd4, 4'd1, 4'd15, 4'd15};
        w = {32'($urandom), {8'd0, 8'hFF, 8'd127, 8'h80}};
        send(x, w, 0);
        x = {4'd0, 4'd2, 4'd5, 4'd15};
        w = {32'($urandom), {4{8'd1}}};
        send(x, w, 2);
        for (int i = 0; i < 30; i++) begin
            x = 16'($urandom);
            if ($urandom_range(0, 3) == 0) x = x & 16'h3333;
            send(x, {$urandom, $urandom}, 3'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();
        // back-pressure: result must hold while out_ready is low, then hand off back-to-back
        or_force = 0;
        send({4{4'd9}}, {$urandom, $urandom}, 0);
        n = 0;
        while (!ov_u && n < 100) begin @(negedge clk); n++; end
        chk("bp_out_valid", ov_u, 1);
        repeat (5) @(negedge clk);
        or_force = 1;
        send(16'($urandom), {$urandom, $urandom}, 0);
        @(negedge clk);
        chk("b2b_out_valid_drop", ov_u, 0);
        chk("b2b_busy_rise", busy_u, 1);
        or_force = -1;
        drain();
        // reset in the middle of a long run discards the result
        send({4{4'd15}}, {$urandom, $urandom}, 0);
        repeat (4) @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        repeat (20) begin
            @(negedge clk);
            chk("post_rst_idle", ov_u, 0);
        end
        for (int i = 0; i < 10; i++)
            send(16'($urandom), {$urandom, $urandom}, 3'($urandom_range(0, 7)));
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tlut_dot_engine.md
# tlut_dot_engine

Parametrised temporal-LUT dot-product engine, successor to the fixed-size TLUT SIMD cell. Computes DIM_C dot products y[c] = Σa W[c][a]·x[a] using unary temporal coding: a counter sweeps upward, and every weight whose input still exceeds the counter is summed through a per-channel adder tree into an accumulator. Generalisations over the previous cell:
- full weight matrix with signed/unsigned weight mode;
- run-time input precision;
- early termination at max(x);
- valid/ready handshakes on input and output.

## Interface
- DIM_A, default 4: inputs per dot product (adder-tree fan-in).
- DIM_C, default 4: output channels.
- INPUT_WIDTH, default 4: unsigned input width.
- WEIGHT_WIDTH, default 8: weight width.
- W_SIGNED, default 0: 1 means weights are two's complement and out_y is signed.
- ACC_WIDTH, default WEIGHT_WIDTH+INPUT_WIDTH+$clog2(DIM_A): accumulator/output width; no overflow is possible at this width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand set valid.
- in_ready  out  1  engine accepts operands this cycle.
- in_x  in  [DIM_A][INPUT_WIDTH]  unsigned inputs.
- in_w  in  [DIM_C][DIM_A][WEIGHT_WIDTH]  weight matrix.
- in_prec  in  $clog2(INPUT_WIDTH)+1  active input bits; 0 or >INPUT_WIDTH means full width.
- out_valid  out  1  results valid.
- out_ready  in  1  consumer takes results.
- out_y  out  [DIM_C][ACC_WIDTH]  dot products.
- busy  out  1  high in RUN.

## Operation
- States: IDLE, RUN, DONE.
- **Accept:** fires when in_valid && in_ready.
  - x_reg[a] = in_x[a] masked to the low in_prec bits.
  - w_reg = in_w.
  - acc cleared, cnt = 0, next state RUN.
- **RUN:** temporal[a] = (x_reg[a] > cnt).
  - If any temporal bit is set: acc[c] += Σa (temporal[a] ? ext(w_reg[c][a]) : 0), and cnt++.
  - If no temporal bit is set: go to DONE with no accumulate.
  - ext() sign-extends when W_SIGNED=1, otherwise zero-extends.
- **DONE:** out_valid=1 and out_y = acc, held stable until out_ready.
  - out_valid && out_ready with no accept: go to IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is combinational on out_ready.
  - Accept in DONE goes directly to RUN (back-to-back operation).
- cnt is INPUT_WIDTH bits wide and never wraps: its terminal value is max(x_reg) ≤ 2^INPUT_WIDTH−1.
- in_valid is ignored in RUN. Operand registers are never modified outside an accept.
- **Reset:** asserting rst at any time, including mid-RUN, forces IDLE, acc/out_y = 0, out_valid=0, busy=0, in_ready=1, cnt=0, x_reg/w_reg=0. Any in-flight result is discarded.

## Timing
- Accept edge T, with m = max(masked x).
  - Accumulating edges are T+1..T+m.
  - State becomes DONE at edge T+m+1; out_valid is visible from that edge.
  - Latency is m+1 cycles. All-zero inputs give 1 cycle.
- busy is high for exactly m+1 cycles.
- out_valid falls on the edge after out_valid && out_ready.
  - If an accept happens in that same cycle, busy rises on that same edge.
- The adder tree is combinational within a single cycle, with no extra pipeline stage. out_y is registered (it is acc).

## Structure
- Package tlut_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - function acc_width(iw, ww, dim_a);
  - function prec_mask(prec, iw).
- Sub-module tlut_adder_tree is parameterised on N=DIM_A, IN_W=ACC_WIDTH and SIGNED.
  - It is a balanced binary reduction of N masked operands.
  - DIM_C instances, one per channel.
- The top level holds the FSM, cnt, operand registers and accumulators.

## Test plan
- **Reset:** hold rst high 3 cycles, then release.
  - Expect out_valid=0, out_y all 0, in_ready=1, busy=0.
- **Unsigned dot products:** DIM_A=4, DIM_C=2, IW=4, WW=8, W_SIGNED=0.
  - Stimulus: x={3,0,15,7}, W[0]={1,2,3,4}, W[1]={255,255,255,255}.
  - Expect y0=76, y1=6375, out_valid 16 cycles after accept.
- **Zero inputs:** x={0,0,0,0} with any W.
  - Expect out_y all 0, latency 1, busy high for 1 cycle.
- **Signed weights:** W_SIGNED=1, x={15,15,1,4}, W[0]={−128,127,−1,0}.
  - Expect y0=−16 (sign-correct at ACC_WIDTH), latency 16.
- **Precision masking:** in_prec=2, x={15,5,2,0}, W[0]={1,1,1,1}.
  - Masked x is {3,1,2,0}, so expect y0=6, latency 4.
- **Back-pressure, back-to-back and mid-RUN reset:**
  - Hold out_ready=0 for 5 cycles: out_y stays stable.
  - Then drive out_ready=1 with in_valid=1: accept occurs, out_valid drops next cycle, busy rises.
  - Pulse rst mid-RUN: IDLE, out_valid=0, no result emitted.
